// File: rtl/multi_channel_debouncer.sv
// -----------------------------------------------------------------------------
// multi_channel_debouncer
//
// Debounces N_CH independent raw inputs (switches, buttons). Each channel runs
// a 2-flop synchronizer followed by a 4-state debounce FSM with its own
// counter. Two debounce styles are offered:
//   - delayed (early_mode=0): the output follows the raw level only after it
//     has been stable for eff_thr cycles; shorter glitches are swallowed.
//   - early   (early_mode=1): the output follows the first raw edge at once,
//     then the channel ignores its input for eff_thr cycles (lock-out).
// The style is latched per channel when a transition starts, so changing
// early_mode mid-count has no effect until the next transition.
//
// Ports
//   clk           : single clock, all state on the rising edge
//   reset         : synchronous, active-high
//   noisy_in      : [N_CH] raw asynchronous inputs
//   threshold     : [CNT_W] debounce time in clk cycles (0 behaves as 1)
//   early_mode    : 0 = delayed debounce, 1 = early (lock-out) debounce
//   debounced_out : [N_CH] registered debounced level
//   rise_pulse    : [N_CH] one-cycle pulse on each debounced 0->1
//   fall_pulse    : [N_CH] one-cycle pulse on each debounced 1->0
//   change_any    : OR of all rise/fall pulses
// -----------------------------------------------------------------------------
module multi_channel_debouncer #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   noisy_in,
  input  logic [CNT_W-1:0]  threshold,
  input  logic              early_mode,
  output logic [N_CH-1:0]   debounced_out,
  output logic [N_CH-1:0]   rise_pulse,
  output logic [N_CH-1:0]   fall_pulse,
  output logic              change_any
);

  typedef enum logic [1:0] {
    S_LOW     = 2'd0,
    S_TO_HIGH = 2'd1,
    S_HIGH    = 2'd2,
    S_TO_LOW  = 2'd3
  } state_t;

  // Terminal count for a transition: eff_thr-1 with eff_thr = max(thr,1).
  // A zero threshold therefore needs a single counting cycle.
  function automatic logic [CNT_W-1:0] done_level(input logic [CNT_W-1:0] thr);
    return (thr == '0) ? '0 : (thr - CNT_W'(1));
  endfunction

  logic [N_CH-1:0]  sync_p0;
  logic [N_CH-1:0]  sync_p1;
  logic [CNT_W-1:0] done_cnt;
  logic [N_CH-1:0]  lvl_nxt;

  // Threshold is evaluated live, so lowering it mid-count finishes the
  // transition on the next edge once cnt already meets the new limit.
  assign done_cnt = done_level(threshold);

  // Stage p0/p1: two-flop synchronizer against metastability on raw inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= noisy_in;
      sync_p1 <= sync_p0;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             m;
    logic             m_nxt;
    logic             s;
    logic             done;
    logic             lvl;

    assign s    = sync_p1[i];
    assign done = (cnt >= done_cnt);

    // Stage: per-channel FSM state register
    always_ff @(posedge clk) begin
      if (reset) begin
        state <= S_LOW;
        cnt   <= '0;
        m     <= 1'b0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
        m     <= m_nxt;
      end
    end

    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      m_nxt     = m;
      case (state)
        S_LOW: begin
          if (s) begin
            state_nxt = S_TO_HIGH;
            cnt_nxt   = '0;
            m_nxt     = early_mode;
          end
        end
        S_HIGH: begin
          if (!s) begin
            state_nxt = S_TO_LOW;
            cnt_nxt   = '0;
            m_nxt     = early_mode;
          end
        end
        S_TO_HIGH: begin
          // In early mode the input is locked out until the count completes.
          if (!m && !s) begin
            state_nxt = S_LOW;
          end else if (done) begin
            state_nxt = S_HIGH;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        S_TO_LOW: begin
          if (!m && s) begin
            state_nxt = S_HIGH;
          end else if (done) begin
            state_nxt = S_LOW;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = S_LOW;
        end
      endcase
    end

    // Debounced level seen from the next state: delayed mode keeps the old
    // level during a transition, early mode already shows the new one.
    always_comb begin
      lvl = 1'b0;
      case (state_nxt)
        S_HIGH:    lvl = 1'b1;
        S_TO_LOW:  lvl = ~m_nxt;
        S_TO_HIGH: lvl = m_nxt;
        default:   lvl = 1'b0;
      endcase
    end

    assign lvl_nxt[i] = lvl;
  end

  // Stage: registered outputs; pulses compare the new level with the one
  // currently shown so each edge is flagged exactly once.
  always_ff @(posedge clk) begin
    if (reset) begin
      debounced_out <= '0;
      rise_pulse    <= '0;
      fall_pulse    <= '0;
      change_any    <= 1'b0;
    end else begin
      debounced_out <= lvl_nxt;
      rise_pulse    <= lvl_nxt & ~debounced_out;
      fall_pulse    <= ~lvl_nxt & debounced_out;
      change_any    <= |(lvl_nxt ^ debounced_out);
    end
  end

endmodule

// File: doc/multi_channel_debouncer.md
MULTI_CHANNEL_DEBOUNCER -- requirements
Module: multi_channel_debouncer

Interface
REQ-001 Parameter N_CH, default 4: number of independent input channels, range 1..32.
REQ-002 Parameter CNT_W, default 16: width of each per-channel debounce counter and of the threshold input.
REQ-003 Port clk, input, 1: single clock; all state is updated on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port noisy_in, input, N_CH: raw asynchronous channel inputs (switches, buttons).
REQ-006 Port threshold, input, CNT_W: debounce time in clk cycles, shared by all channels; a value of 0 is treated as 1.
REQ-007 Port early_mode, input, 1: 0 selects delayed debounce; 1 selects early (lock-out) debounce.
REQ-008 Port debounced_out, output, N_CH: debounced level per channel.
REQ-009 Port rise_pulse, output, N_CH: one-cycle pulse on each debounced 0->1 transition.
REQ-010 Port fall_pulse, output, N_CH: one-cycle pulse on each debounced 1->0 transition.
REQ-011 Port change_any, output, 1: OR of all rise_pulse and fall_pulse bits.

Function
REQ-012 Each channel SHALL pass noisy_in through a 2-flop synchronizer; the synchronized value s drives that channel's FSM.
REQ-013 Each channel SHALL implement a 4-state FSM: S_LOW, S_TO_HIGH, S_HIGH, S_TO_LOW, with a CNT_W-bit counter cnt and a latched mode bit m.
REQ-014 S_LOW: s=1 -> S_TO_HIGH, cnt<=0, m<=early_mode; otherwise stay.
REQ-015 S_HIGH: s=0 -> S_TO_LOW, cnt<=0, m<=early_mode; otherwise stay.
REQ-016 Done condition: cnt >= eff_thr-1, where eff_thr = max(threshold,1); threshold is compared live every cycle.
REQ-017 S_TO_HIGH with m=0: s=0 -> S_LOW; else if done -> S_HIGH; else cnt++.
REQ-018 S_TO_LOW with m=0: s=1 -> S_HIGH; else if done -> S_LOW; else cnt++.
REQ-019 S_TO_HIGH / S_TO_LOW with m=1: s is ignored; if done -> S_HIGH / S_LOW respectively; else cnt++.
REQ-020 debounced_out SHALL be registered and equal 1 in S_HIGH, in S_TO_LOW when m=0, and in S_TO_HIGH when m=1; 0 otherwise.
REQ-021 Mode change: early_mode SHALL affect a channel only at entry into a transitional state; a change mid-count is ignored until the next entry.
REQ-022 Counter SHALL never wrap: cnt stops at the done value and the FSM leaves the transitional state on that cycle.
REQ-023 Threshold lowered mid-count to a value <= cnt+1 SHALL complete the transition on the next edge.
REQ-024 rise_pulse[i] = debounced_out[i] & ~previous debounced_out[i]; it is high only during the first cycle the new level is visible. fall_pulse is the inverse case.
REQ-025 Delayed-mode latency: debounced_out changes eff_thr+3 rising edges after the first edge that samples the new raw level, provided the level stays stable.
REQ-026 Early-mode latency: debounced_out changes 3 edges after the first sampling edge; further raw edges are ignored for eff_thr cycles.
REQ-027 A glitch shorter than eff_thr cycles (post-synchronizer) in delayed mode SHALL produce no change on debounced_out and no pulses.
REQ-028 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.

Reset
REQ-029 While reset=1 at a clk edge: synchronizers <= 0, all FSMs <= S_LOW, cnt <= 0, m <= 0, debounced_out <= 0, rise_pulse/fall_pulse/change_any <= 0.
REQ-030 Reset asserted mid-count or in S_HIGH SHALL force S_LOW without producing a fall_pulse.
REQ-031 Behaviour after reset deassertion SHALL be identical to power-up; a high noisy_in then takes the normal S_LOW->S_TO_HIGH path.

Verification
REQ-032 Delayed mode, threshold=4, ch0 held high -> debounced_out[0]=1 at edge 7, rise_pulse[0] high for exactly 1 cycle, change_any=1 for that same cycle.
REQ-033 Delayed mode, threshold=4, ch1 high for 2 cycles then low -> debounced_out[1] stays 0 and no pulses occur.
REQ-034 Early mode, threshold=8, ch2 toggled every cycle for 6 cycles from low -> debounced_out[2]=1 at edge 3, remains 1 through the lock-out, and the channel then follows the stable level.
REQ-035 threshold=0 -> behaves as threshold=1 (delayed latency of 4 edges).
REQ-036 All 4 channels rise on the same cycle, threshold=2 -> all rise_pulse bits high in the same cycle, change_any=1 for 1 cycle.
REQ-037 Reset pulsed while ch3 is in S_HIGH -> next cycle debounced_out[3]=0, fall_pulse[3]=0, and cnt=0.
